div_share_arb: RTL
==================

DIV_SHARE_ARB -- requirements
Module: div_share_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of requesters sharing one serial divider (2..8).
REQ-002 SHALL have parameter WIDTH, default 64: operand and result width.
REQ-003 SHALL have parameter ID_BITS, default 3: transaction ID width.
REQ-004 SHALL have ports:
- clk_i in 1: clock.
- rst_ni in 1: reset, asynchronous, active-low.
- req_vld_i in NUM_REQ: request valid.
- req_rdy_o out NUM_REQ: request accepted.
- req_op_a_i in NUM_REQ x WIDTH: dividend.
- req_op_b_i in NUM_REQ x WIDTH: divisor.
- req_opcode_i in NUM_REQ x 2: 0 udiv, 1 div, 2 urem, 3 rem.
- req_id_i in NUM_REQ x ID_BITS: requester transaction ID.
- flush_i in NUM_REQ: per-requester flush.
- rsp_vld_o out NUM_REQ: result valid.
- rsp_rdy_i in NUM_REQ: result taken.
- rsp_res_o out WIDTH: result, shared bus.
- rsp_id_o out ID_BITS: ID echoed to the owner.
- div_vld_o, div_op_a_o, div_op_b_o, div_opcode_o, div_id_o out 1/WIDTH/WIDTH/2/ID_BITS: divider issue.
- div_flush_o out 1: divider abort.
- div_out_vld_i in 1, div_res_i in WIDTH: divider result.
- div_out_rdy_o out 1: result accept to the divider.

Function
REQ-005 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-006 In IDLE with any req_vld_i high, SHALL grant round-robin starting at index rr_q+1 mod NUM_REQ.
- SHALL assert req_rdy_o[grant] and div_vld_o in that same cycle, with div_* driven combinationally from the granted requester.
- SHALL latch owner, ID and operands, and go BUSY.
REQ-007 SHALL set rr_q to the grant index on every grant; rr_q wraps NUM_REQ-1 -> 0.
REQ-008 div_vld_o SHALL be a single-cycle pulse, asserted only in IDLE; the divider is idle whenever the arbiter is in IDLE.
REQ-009 req_rdy_o SHALL be zero outside the grant cycle; at most one bit SHALL be set.
REQ-010 In BUSY, on div_out_vld_i the arbiter SHALL register div_res_i into res_q, pulse div_out_rdy_o in the same cycle, and go RESP.
REQ-011 In RESP, SHALL drive rsp_vld_o[owner] from res_q and id_q, hold it stable until rsp_rdy_i[owner], then go IDLE.
- A new grant is permitted no earlier than the following cycle.
REQ-012 rsp_vld_o SHALL be one-hot or zero; rsp_res_o/rsp_id_o SHALL hold the last values when no response is pending.
REQ-013 Flush in BUSY when flush_i[owner] is set: SHALL pulse div_flush_o for one cycle, go IDLE, and produce no response.
REQ-014 Flush in RESP when flush_i[owner] is set: SHALL drop rsp_vld_o in the next cycle and go IDLE.
REQ-015 flush_i of a non-owner SHALL be ignored; flush_i[i] in a grant cycle SHALL suppress the grant to i, and arbitration SHALL proceed among the others.
REQ-016 Minimum turnaround SHALL be grant -> divider latency -> 1 cycle RESP; back-to-back grants SHALL be separated by at least 1 IDLE cycle.

Reset
REQ-017 While rst_ni is low, SHALL force state IDLE, rr_q=NUM_REQ-1, owner/id_q/res_q=0, and all *_vld_o/*_rdy_o/div_flush_o=0.
REQ-018 Reset mid-BUSY SHALL not emit div_flush_o; the divider shares rst_ni.

Configuration
REQ-019 Macro DIV_SHARE_ARB_RESULT_CACHE_EN defined: SHALL keep {op_a, op_b, opcode, result} of the last completed, unflushed division.
- A grant whose operands and opcode match the cache SHALL skip the divider: no div_vld_o, go RESP the next cycle with the cached result.
- The cache SHALL be invalidated at reset only.
REQ-020 Macro undefined: SHALL contain no cache storage; every grant issues to the divider.

Verification
REQ-021 Both requesters valid at reset release -> grant 0 first, then 1; grants alternate 0,1,0 under continuous valid.
REQ-022 Req0 udiv 100/7 with the divider returning 14 -> rsp_vld_o[0]=1, rsp_res_o=14, rsp_id_o=req id; held 3 cycles with rsp_rdy_i low, unchanged throughout.
REQ-023 flush_i[0] two cycles after grant to 0 -> div_flush_o single pulse, no rsp_vld_o[0], next grant to waiting req1 after one IDLE cycle.
REQ-024 flush_i[1] while 0 owns BUSY -> ignored; req0 response delivered normally.
REQ-025 With cache enabled: req1 div -100/7 repeated after completion -> no div_vld_o, rsp_res_o=-14 two cycles after grant; without macro -> div_vld_o pulses.
REQ-026 rst_ni low mid-BUSY -> all outputs 0 asynchronously; first post-reset grant goes to index 0.

Source files
------------

// File: rtl/div_share_arb.sv
// -----------------------------------------------------------------------------
// div_share_arb
// Shares one serial divider among NUM_REQ requesters. A round-robin arbiter
// grants one request at a time, issues it to the divider, captures the result
// and hands it back to the owning requester on a shared response bus.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_vld_i/req_rdy_o    per-requester request handshake
//   req_op_a_i/op_b_i      per-requester dividend / divisor
//   req_opcode_i           0 udiv, 1 div, 2 urem, 3 rem
//   req_id_i               per-requester transaction ID
//   flush_i                per-requester abort of its own transaction
//   rsp_vld_o/rsp_rdy_i    per-requester response handshake
//   rsp_res_o, rsp_id_o    shared response bus (holds last values when idle)
//   div_vld_o, div_op_a_o, div_op_b_o, div_opcode_o, div_id_o   divider issue
//   div_flush_o            divider abort
//   div_out_vld_i, div_res_i, div_out_rdy_o                     divider result
//
// Build option
//   DIV_SHARE_ARB_RESULT_CACHE_EN : remember the last completed, unflushed
//   division; a grant with identical operands/opcode skips the divider.
// -----------------------------------------------------------------------------
module div_share_arb #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 64,
    parameter int ID_BITS = 3
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_REQ-1:0]                req_vld_i,
    output logic [NUM_REQ-1:0]                req_rdy_o,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]     req_op_a_i,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]     req_op_b_i,
    input  logic [NUM_REQ-1:0][1:0]           req_opcode_i,
    input  logic [NUM_REQ-1:0][ID_BITS-1:0]   req_id_i,
    input  logic [NUM_REQ-1:0]                flush_i,
    output logic [NUM_REQ-1:0]                rsp_vld_o,
    input  logic [NUM_REQ-1:0]                rsp_rdy_i,
    output logic [WIDTH-1:0]                  rsp_res_o,
    output logic [ID_BITS-1:0]                rsp_id_o,
    output logic                              div_vld_o,
    output logic [WIDTH-1:0]                  div_op_a_o,
    output logic [WIDTH-1:0]                  div_op_b_o,
    output logic [1:0]                        div_opcode_o,
    output logic [ID_BITS-1:0]                div_id_o,
    output logic                              div_flush_o,
    input  logic                              div_out_vld_i,
    input  logic [WIDTH-1:0]                  div_res_i,
    output logic                              div_out_rdy_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e               state_r;
    state_e               state_s;
    logic [IDX_W-1:0]     rr_r;
    logic [IDX_W-1:0]     owner_r;
    logic [ID_BITS-1:0]   id_r;
    logic [WIDTH-1:0]     res_r;

    logic [NUM_REQ-1:0]   elig_s;
    logic [IDX_W-1:0]     grant_idx_s;
    logic                 found_s;
    logic                 grant_s;
    logic                 hit_s;
    logic [WIDTH-1:0]     hit_res_s;
    logic                 take_s;

    // A requester flushing this cycle cannot be granted.
    assign elig_s = req_vld_i & ~flush_i;

    // Round-robin pick: first eligible above rr_r, then wrap to the lowest.
    always_comb begin
        grant_idx_s = rr_r;
        found_s     = 1'b0;
        take_s      = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            take_s      = !found_s && elig_s[i] && (IDX_W'(i) > rr_r);
            grant_idx_s = take_s ? IDX_W'(i) : grant_idx_s;
            found_s     = found_s | take_s;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            take_s      = !found_s && elig_s[i] && (IDX_W'(i) <= rr_r);
            grant_idx_s = take_s ? IDX_W'(i) : grant_idx_s;
            found_s     = found_s | take_s;
        end
    end

    // rst_ni gates the grant so nothing handshakes while reset is held.
    assign grant_s      = rst_ni && (state_r == IDLE) && found_s;

    assign div_op_a_o   = req_op_a_i[grant_idx_s];
    assign div_op_b_o   = req_op_b_i[grant_idx_s];
    assign div_opcode_o = req_opcode_i[grant_idx_s];
    assign div_id_o     = req_id_i[grant_idx_s];
    assign div_vld_o    = grant_s && !hit_s;

    assign rsp_res_o    = res_r;
    assign rsp_id_o     = id_r;

    // One-hot ready to the requester granted this cycle.
    always_comb begin
        req_rdy_o = {NUM_REQ{1'b0}};
        if (grant_s) begin
            req_rdy_o[grant_idx_s] = 1'b1;
        end else begin
            req_rdy_o = {NUM_REQ{1'b0}};
        end
    end

    // Next-state and handshake outputs; owner flush wins over a result.
    always_comb begin
        state_s       = state_r;
        div_flush_o   = 1'b0;
        div_out_rdy_o = 1'b0;
        rsp_vld_o     = {NUM_REQ{1'b0}};
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_s = hit_s ? RESP : BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (flush_i[owner_r]) begin
                    div_flush_o = 1'b1;
                    state_s     = IDLE;
                end else if (div_out_vld_i) begin
                    div_out_rdy_o = 1'b1;
                    state_s       = RESP;
                end else begin
                    state_s = BUSY;
                end
            end
            RESP: begin
                rsp_vld_o[owner_r] = 1'b1;
                if (flush_i[owner_r] || rsp_rdy_i[owner_r]) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, round-robin pointer, owner and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            rr_r    <= IDX_W'(NUM_REQ - 1);
            owner_r <= {IDX_W{1'b0}};
            id_r    <= {ID_BITS{1'b0}};
            res_r   <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            if (grant_s) begin
                rr_r    <= grant_idx_s;
                owner_r <= grant_idx_s;
                id_r    <= req_id_i[grant_idx_s];
            end
            if (grant_s && hit_s) begin
                res_r <= hit_res_s;
            end else if (div_out_rdy_o) begin
                res_r <= div_res_i;
            end
        end
    end

`ifdef DIV_SHARE_ARB_RESULT_CACHE_EN
    logic               cache_vld_r;
    logic [WIDTH-1:0]   cache_a_r;
    logic [WIDTH-1:0]   cache_b_r;
    logic [1:0]         cache_op_r;
    logic [WIDTH-1:0]   cache_res_r;
    logic [WIDTH-1:0]   op_a_r;
    logic [WIDTH-1:0]   op_b_r;
    logic [1:0]         opcode_r;

    // Match the candidate request against the remembered division.
    always_comb begin
        hit_s     = cache_vld_r &&
                    (req_op_a_i[grant_idx_s]   == cache_a_r) &&
                    (req_op_b_i[grant_idx_s]   == cache_b_r) &&
                    (req_opcode_i[grant_idx_s] == cache_op_r);
        hit_res_s = cache_res_r;
    end

    // Operands are kept from grant so a completing division can be cached.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cache_vld_r <= 1'b0;
            cache_a_r   <= {WIDTH{1'b0}};
            cache_b_r   <= {WIDTH{1'b0}};
            cache_op_r  <= 2'd0;
            cache_res_r <= {WIDTH{1'b0}};
            op_a_r      <= {WIDTH{1'b0}};
            op_b_r      <= {WIDTH{1'b0}};
            opcode_r    <= 2'd0;
        end else begin
            if (grant_s) begin
                op_a_r   <= div_op_a_o;
                op_b_r   <= div_op_b_o;
                opcode_r <= div_opcode_o;
            end
            if (div_out_rdy_o) begin
                cache_vld_r <= 1'b1;
                cache_a_r   <= op_a_r;
                cache_b_r   <= op_b_r;
                cache_op_r  <= opcode_r;
                cache_res_r <= div_res_i;
            end
        end
    end
`else
    assign hit_s     = 1'b0;
    assign hit_res_s = res_r;
`endif

endmodule
